// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that
// shares one uart_tx byte port between sources.
module uart_tx_arbiter #(
  parameter  int NUM_REQUESTERS = 4,
  parameter  int NUMBER_OF_BITS = 8,
  parameter  int MAX_BURST      = 16,
  localparam int IDX_W =
    ($clog2(NUM_REQUESTERS) < 1) ? 1
      : $clog2(NUM_REQUESTERS),
  localparam int BC_W =
    ($clog2(MAX_BURST + 1) < 1) ? 1
      : $clog2(MAX_BURST + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_REQUESTERS-1:0] req_valid,
  output logic [NUM_REQUESTERS-1:0] req_ready,
  input  logic [NUM_REQUESTERS*NUMBER_OF_BITS-1:0]
                              req_data,
  input  logic [NUM_REQUESTERS-1:0] req_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUMBER_OF_BITS-1:0] out_data,
  output logic                grant_valid,
  output logic [IDX_W-1:0]    grant_index
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [BC_W-1:0] BC_LIM =
    BC_W'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

  logic [0:0]       state;
  logic [IDX_W-1:0] last_grant;
  logic [BC_W-1:0]  beat_count;
  logic [IDX_W-1:0] winner;
  logic             found;
  logic             hs;
  logic             at_limit;
  logic             release_now;

  // Round-robin scan starting just past last_grant
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQUESTERS; k++) begin
      if (!found &&
          req_valid[(int'(last_grant) + k)
                    % NUM_REQUESTERS]) begin
        found  = 1'b1;
        winner = IDX_W'((int'(last_grant) + k)
                        % NUM_REQUESTERS);
      end
    end
  end

  // Combinational path from grantee to out port
  always_comb begin
    out_valid = 1'b0;
    req_ready = '0;
    out_data  = req_data[grant_index*NUMBER_OF_BITS
                         +: NUMBER_OF_BITS];
    if (state == BUSY) begin
      out_valid = req_valid[grant_index];
      req_ready[grant_index] = out_ready;
    end
  end

  assign grant_valid = (state == BUSY);
  assign hs          = out_valid && out_ready;
  assign at_limit    = (MAX_BURST != 0) &&
                       (beat_count == BC_LIM);
  assign release_now = hs &&
    (req_last[grant_index] || at_limit);

  // Grant FSM: lock until last beat or burst limit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant_index <= '0;
      last_grant  <= IDX_W'(NUM_REQUESTERS - 1);
      beat_count  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant_index <= winner;
            beat_count  <= '0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (hs)
            beat_count <= beat_count + BC_W'(1);
          if (release_now) begin
            last_grant <= grant_index;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter:
// queued requesters, expected-beat queue, monitor.
module tb_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic        out_ready = 1'b1;

  logic [3:0]  rdy_a, rdy_b;
  logic        ov_a, ov_b, gv_a, gv_b;
  logic [7:0]  od_a, od_b;
  logic [1:0]  gi_a, gi_b;

  logic        sel = 1'b0;
  logic        pace = 1'b0;
  logic [3:0]  rdy_s;
  logic        ov, gv;
  logic [7:0]  od;
  logic [1:0]  gi;

  int tests = 0;
  int fails = 0;

  logic [8:0]  mem [4][64];
  int          hd [4];
  int          tl [4];
  logic [9:0]  sb [$];
  logic [3:0]  hs_cap;
  int          cnt = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  always #5 clock = ~clock;

  uart_tx_arbiter #(
    .NUM_REQUESTERS(4),
    .NUMBER_OF_BITS(8),
    .MAX_BURST(16)
  ) u_a (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(rdy_a),
    .req_data(req_data), .req_last(req_last),
    .out_valid(ov_a), .out_ready(out_ready),
    .out_data(od_a), .grant_valid(gv_a),
    .grant_index(gi_a)
  );

  uart_tx_arbiter #(
    .NUM_REQUESTERS(4),
    .NUMBER_OF_BITS(8),
    .MAX_BURST(4)
  ) u_b (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(rdy_b),
    .req_data(req_data), .req_last(req_last),
    .out_valid(ov_b), .out_ready(out_ready),
    .out_data(od_b), .grant_valid(gv_b),
    .grant_index(gi_b)
  );

  assign rdy_s = sel ? rdy_b : rdy_a;
  assign ov    = sel ? ov_b  : ov_a;
  assign gv    = sel ? gv_b  : gv_a;
  assign od    = sel ? od_b  : od_a;
  assign gi    = sel ? gi_b  : gi_a;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  task automatic push(input int r,
                      input logic [7:0] d,
                      input logic l);
    mem[r][tl[r]] = {l, d};
    tl[r]++;
  endtask

  task automatic expb(input int r,
                      input logic [7:0] d);
    logic [1:0] ri;
    ri = r[1:0];
    sb.push_back({ri, d});
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    sb.delete();
  endtask

  // Requester model: pop on handshake, present next byte
  initial begin
    for (int i = 0; i < 4; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    forever begin
      @(negedge clock);
      hs_cap = req_valid & rdy_s;
      @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (hs_cap[i] && hd[i] < tl[i]) hd[i]++;
        if (hd[i] < tl[i]) begin
          req_valid[i] = 1'b1;
          req_data[i*8 +: 8] = mem[i][hd[i]][7:0];
          req_last[i] = mem[i][hd[i]][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      cnt++;
      out_ready = pace ? ((cnt % 40) == 39) : 1'b1;
    end
  end

  // Monitor: compare each accepted beat to scoreboard
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && ov)
        chk("hold_data", {24'd0, od},
            {24'd0, prev_data});
      if (ov && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", {24'd0, od},
              32'hFFFF_FFFF);
        end else begin
          logic [9:0] e;
          e = sb.pop_front();
          chk("beat_index", {30'd0, gi},
              {30'd0, e[9:8]});
          chk("beat_data", {24'd0, od},
              {24'd0, e[7:0]});
        end
      end
      prev_stall <= ov && !out_ready;
      prev_data  <= od;
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    pace = 1'b0;
    @(negedge clock);
    @(negedge clock);
    flush();
  endtask

  task automatic release_rst();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic drain(input string nm,
                       input int bound);
    int k;
    for (k = 0; k < bound; k++) begin
      @(negedge clock);
      if (sb.size() == 0 && !gv &&
          hd[0] == tl[0] && hd[1] == tl[1] &&
          hd[2] == tl[2] && hd[3] == tl[3])
        break;
    end
    chk(nm, sb.size(), 0);
    if (k == bound)
      chk({nm, "_timeout"}, k, 0);
  endtask

  initial begin
    int k;
    int bad;

    do_reset();
    chk("rst_out_valid", {31'd0, ov_a}, 0);
    chk("rst_req_ready", {28'd0, rdy_a}, 0);
    chk("rst_grant_valid", {31'd0, gv_a}, 0);
    chk("rst_grant_index", {30'd0, gi_a}, 0);
    chk("rst_last_grant",
        {30'd0, u_a.last_grant}, 3);

    // Single requester, 3-byte packet
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    push(2, 8'h41, 1'b0);
    push(2, 8'h42, 1'b0);
    push(2, 8'h43, 1'b1);
    expb(2, 8'h41);
    expb(2, 8'h42);
    expb(2, 8'h43);
    for (k = 0; k < 10; k++) begin
      @(negedge clock);
      if (req_valid[2]) break;
    end
    chk("t1_req_seen", k < 10, 1);
    chk("t1_idle_first", {31'd0, ov_a}, 0);
    @(negedge clock);
    chk("t1_valid_b0", {31'd0, ov_a}, 1);
    chk("t1_grant_b0", {31'd0, gv_a}, 1);
    @(negedge clock);
    chk("t1_valid_b1", {31'd0, ov_a}, 1);
    @(negedge clock);
    chk("t1_valid_b2", {31'd0, ov_a}, 1);
    @(negedge clock);
    chk("t1_bubble", {31'd0, gv_a}, 0);
    chk("t1_last_grant",
        {30'd0, u_a.last_grant}, 2);
    drain("t1_drain", 20);

    // Contention: 0,1,2,3,0 with bubbles
    do_reset();
    push(0, 8'hA0, 1'b1);
    push(0, 8'hA4, 1'b1);
    push(1, 8'hA1, 1'b1);
    push(2, 8'hA2, 1'b1);
    push(3, 8'hA3, 1'b1);
    expb(0, 8'hA0);
    expb(1, 8'hA1);
    expb(2, 8'hA2);
    expb(3, 8'hA3);
    expb(0, 8'hA4);
    release_rst();
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk("t2_grant_pattern", {31'd0, gv_a},
          (c % 2 == 0) ? 1 : 0);
    end
    drain("t2_drain", 20);

    // Lock: requester 1 packet vs waiting requester 0
    do_reset();
    for (int b = 1; b <= 5; b++) begin
      push(1, 8'hC0 + 8'(b), b == 5);
      expb(1, 8'hC0 + 8'(b));
    end
    expb(0, 8'hB0);
    release_rst();
    for (k = 0; k < 20; k++) begin
      @(negedge clock);
      if (gv_a && gi_a == 2'd1) break;
    end
    chk("t3_grant1", k < 20, 1);
    push(0, 8'hB0, 1'b1);
    bad = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clock);
      if (rdy_a[0]) bad++;
      if (ov_a && out_ready && od_a == 8'hC5) break;
    end
    chk("t3_r0_blocked", bad, 0);
    @(negedge clock);
    chk("t3_release_idle", {31'd0, gv_a}, 0);
    @(negedge clock);
    chk("t3_next_grant", {30'd0, gi_a}, 0);
    drain("t3_drain", 20);

    // Burst limit 4 on second instance
    do_reset();
    sel = 1'b1;
    for (int b = 0; b < 10; b++)
      push(0, 8'hD0 + 8'(b), b == 9);
    push(3, 8'hE3, 1'b1);
    for (int b = 0; b < 4; b++)
      expb(0, 8'hD0 + 8'(b));
    expb(3, 8'hE3);
    for (int b = 4; b < 10; b++)
      expb(0, 8'hD0 + 8'(b));
    release_rst();
    drain("t4_drain", 60);
    sel = 1'b0;

    // Backpressure: ready one cycle in forty
    do_reset();
    pace = 1'b1;
    push(1, 8'hF1, 1'b0);
    push(1, 8'hF2, 1'b0);
    push(1, 8'hF3, 1'b1);
    push(2, 8'h61, 1'b0);
    push(2, 8'h62, 1'b1);
    expb(1, 8'hF1);
    expb(1, 8'hF2);
    expb(1, 8'hF3);
    expb(2, 8'h61);
    expb(2, 8'h62);
    release_rst();
    drain("t5_drain", 1500);
    pace = 1'b0;

    // Reset during second byte of a 4-byte packet
    do_reset();
    push(2, 8'h70, 1'b0);
    push(2, 8'h71, 1'b0);
    push(2, 8'h72, 1'b0);
    push(2, 8'h73, 1'b1);
    expb(2, 8'h70);
    expb(2, 8'h71);
    release_rst();
    for (k = 0; k < 20; k++) begin
      @(negedge clock);
      if (ov_a && od_a == 8'h71) break;
    end
    chk("t6_second_byte", k < 20, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, ov_a}, 0);
    chk("t6_rst_ready", {28'd0, rdy_a}, 0);
    chk("t6_rst_grant", {31'd0, gv_a}, 0);
    chk("t6_rst_index", {30'd0, gi_a}, 0);
    @(negedge clock);
    @(negedge clock);
    chk("t6_sb_empty", sb.size(), 0);
    flush();
    push(0, 8'h80, 1'b1);
    push(2, 8'h82, 1'b1);
    expb(0, 8'h80);
    expb(2, 8'h82);
    release_rst();
    drain("t6_drain", 20);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` byte port between `NUM_REQUESTERS` independent byte-stream sources. Each requester sends packets (byte sequences ending in a `last` beat). Once a requester is granted, the arbiter locks onto it until the packet ends or a burst limit is hit, so packets from different sources are not interleaved on the serial line. It sits directly upstream of `uart_tx`. Its downstream valid/ready/data outputs drive `uart_tx`'s `data_valid`/`data_ready`/`data_bits`.

## Interface
- `NUM_REQUESTERS`, 4: number of sources; must be ≥ 2.
- `NUMBER_OF_BITS`, 8: byte width; matches `uart_tx`.
- `MAX_BURST`, 16: maximum beats per grant before forced release; 0 = unlimited (release only on `last`).

Ports:
- `clock`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQUESTERS  per-requester byte valid.
- `req_ready`  out  NUM_REQUESTERS  per-requester byte accepted.
- `req_data`  in  NUM_REQUESTERS*NUMBER_OF_BITS  requester i occupies bits [i*NUMBER_OF_BITS +: NUMBER_OF_BITS].
- `req_last`  in  NUM_REQUESTERS  marks final byte of a packet.
- `out_valid`  out  1  to `uart_tx.data_valid`.
- `out_ready`  in  1  from `uart_tx.data_ready`.
- `out_data`  out  NUMBER_OF_BITS  to `uart_tx.data_bits`.
- `grant_valid`  out  1  high while in BUSY.
- `grant_index`  out  IDX_W  current or most recent grantee; IDX_W = max(1, $clog2(NUM_REQUESTERS)).

## Operation
- Two states: IDLE and BUSY. Registers: `state`, `grant_index`, `last_grant` (IDX_W), `beat_count` ($clog2(MAX_BURST+1) bits, min 1).
- Reset values: state = IDLE, grant_index = 0, last_grant = NUM_REQUESTERS-1 (requester 0 has first priority), beat_count = 0.
- Output values during reset: out_valid = 0, req_ready = 0, grant_valid = 0.
- IDLE:
  - All req_ready = 0 and out_valid = 0.
  - If any req_valid is set, the winner is the first set bit scanning last_grant+1, last_grant+2, … with modulo NUM_REQUESTERS wrap.
  - Register winner into grant_index, clear beat_count, go to BUSY.
- BUSY:
  - out_valid = req_valid[grant_index]; out_data = req_data slice of grant_index.
  - req_ready[grant_index] = out_ready; all other req_ready = 0.
  - out_data is undefined when out_valid = 0.
- Handshake = out_valid && out_ready. On each handshake, beat_count increments.
- Release occurs on a handshake with req_last[grant_index] = 1, or with MAX_BURST ≠ 0 and beat_count == MAX_BURST-1.
  - On release: last_grant ← grant_index, state ← IDLE.
- req_valid of the grantee dropping mid-packet: stay in BUSY, keep the lock, no timeout.
- Requests from non-granted sources during BUSY are ignored until the next IDLE arbitration.
- A requester that was force-released mid-packet re-competes normally. Its remaining bytes form a new grant; the lock is not preserved.
- grant_index holds its value in IDLE.

## Timing
- Arbitration latency: one cycle. A req_valid seen in IDLE at edge N gives grant_valid = 1 and out_valid in cycle N+1.
- In BUSY the datapath is combinational from the granted requester to the out port: zero added latency and full throughput, one beat per cycle if out_ready allows.
- Release costs one IDLE cycle. Back-to-back packets therefore have at least one bubble cycle between them. This is negligible against the UART bit time.
- Beat that releases: the release transition takes effect at the same edge as that beat's handshake.
- Asynchronous reset mid-packet:
  - State goes to IDLE immediately and outputs go to their reset values.
  - A byte already latched by `uart_tx` is `uart_tx`'s concern.
  - Requesters must treat the packet as aborted.
- Deassertion of reset_n must be synchronised externally to `clock`.

## Test plan
- Single requester: requester 2 sends a 3-byte packet 0x41,0x42,0x43 (last on 0x43), with out_ready = 1. Expect out_valid one cycle after req_valid, bytes in order on consecutive cycles, then grant_valid = 0 for ≥ 1 cycle. last_grant = 2.
- Contention: all 4 requesters valid from reset, each sending 1-byte packets (last = 1). Expect grant order 0,1,2,3,0 with one idle cycle between grants.
- Lock: requester 1 sends a 5-byte packet while requester 0 holds valid throughout. Expect requester 0's req_ready = 0 until requester 1's last byte is accepted; requester 0 is granted next.
- Burst limit: MAX_BURST = 4, requester 0 sends a 10-byte packet and requester 3 is also valid. Expect release after beat 4, requester 3 granted next, then requester 0 resumes with byte 5.
- Backpressure: toggle out_ready with `uart_tx`-like pacing (ready 1 cycle every 40). Expect each byte held stable on out_data while out_valid = 1 && out_ready = 0, and no byte lost or duplicated.
- Reset mid-packet: assert reset_n low during the 2nd byte of a 4-byte packet. Expect all outputs to go to reset values in the same cycle. After release, requester 0 is granted first.
